// File: rtl/lsu_byte_mem_if.sv
// Request/response bus between a core and lsu_byte_mem.
// master drives requests and accepts responses; slave is the LSU.
interface lsu_byte_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    modport master (
        output req_valid, req_write, req_funct3,
        output req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_funct3,
        input  req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/lsu_byte_mem.sv
// Load/store unit with a private byte-wide data memory.
// Moves one byte per cycle; bad accesses answer with an error.
module lsu_byte_mem #(
    parameter int ADDR_BITS        = 16,
    parameter bit ALLOW_MISALIGNED = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    lsu_byte_mem_if.slave        bus,
    input  logic                 dbg_we,
    input  logic [ADDR_BITS-1:0] dbg_addr,
    input  logic [7:0]           dbg_wdata,
    output logic [7:0]           dbg_rdata
);

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    state_t               state;
    logic                 wr;
    logic                 bad;
    logic [2:0]           f3;
    logic [ADDR_BITS-1:0] base;
    logic [31:0]          wdata;
    logic [31:0]          lbuf;
    logic [1:0]           cnt;
    logic [1:0]           last;
    logic                 req_ready_q;
    logic                 rsp_valid_q;
    logic                 rsp_error_q;
    logic [31:0]          rsp_rdata_q;

    logic [7:0] mem [0:(2**ADDR_BITS)-1];

    logic [1:0]           dec_last;
    logic                 dec_bad;
    logic [ADDR_BITS-1:0] xaddr;
    logic [7:0]           xbyte;
    logic [7:0]           wbyte;
    logic [31:0]          lbuf_n;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [7:0]           mem_wdata;

    wire unused_addr = &{1'b0, bus.req_addr[31:ADDR_BITS]};

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_error = rsp_error_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    function automatic logic [31:0] extend(
        input logic [2:0]  f,
        input logic [31:0] b
    );
        case (f)
            3'b000:  return {{24{b[7]}}, b[7:0]};
            3'b001:  return {{16{b[15]}}, b[15:0]};
            3'b100:  return {24'd0, b[7:0]};
            3'b101:  return {16'd0, b[15:0]};
            default: return b;
        endcase
    endfunction

    // Decode width and legality of the request on the bus.
    always_comb begin
        dec_last = 2'd0;
        dec_bad  = 1'b0;
        case (bus.req_funct3)
            3'b000: dec_last = 2'd0;
            3'b100: begin
                dec_last = 2'd0;
                dec_bad  = bus.req_write;
            end
            3'b001: dec_last = 2'd1;
            3'b101: begin
                dec_last = 2'd1;
                dec_bad  = bus.req_write;
            end
            3'b010: dec_last = 2'd3;
            default: dec_bad = 1'b1;
        endcase
        if (!ALLOW_MISALIGNED) begin
            if (dec_last == 2'd1 && bus.req_addr[0])
                dec_bad = 1'b1;
            if (dec_last == 2'd3 && bus.req_addr[1:0] != 2'd0)
                dec_bad = 1'b1;
        end
    end

    assign xaddr = base + ADDR_BITS'(cnt);
    assign xbyte = mem[xaddr];
    assign wbyte = wdata[{cnt, 3'b000} +: 8];

    // Merge the byte being read into the load buffer.
    always_comb begin
        lbuf_n = lbuf;
        lbuf_n[{cnt, 3'b000} +: 8] = xbyte;
    end

    // Single write port shared by transfers and the backdoor.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
        if (state == XFER) begin
            mem_we    = wr && !bad;
            mem_addr  = xaddr;
            mem_wdata = wbyte;
        end else if (state == IDLE) begin
            mem_we = dbg_we;
        end
    end

    assign dbg_rdata = mem[dbg_addr];

    // Byte array write; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_addr] <= mem_wdata;
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            cnt         <= 2'd0;
            last        <= 2'd0;
            wr          <= 1'b0;
            bad         <= 1'b0;
            f3          <= 3'd0;
            base        <= '0;
            wdata       <= 32'd0;
            lbuf        <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        wr          <= bus.req_write;
                        bad         <= dec_bad;
                        f3          <= bus.req_funct3;
                        base        <= bus.req_addr[ADDR_BITS-1:0];
                        wdata       <= bus.req_wdata;
                        last        <= dec_last;
                        cnt         <= 2'd0;
                        lbuf        <= 32'd0;
                        req_ready_q <= 1'b0;
                        state       <= XFER;
                    end
                end
                XFER: begin
                    if (bad) begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= 1'b1;
                        rsp_rdata_q <= 32'd0;
                    end else begin
                        lbuf <= lbuf_n;
                        if (cnt == last) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_error_q <= 1'b0;
                            rsp_rdata_q <= wr ? 32'd0
                                              : extend(f3, lbuf_n);
                        end else begin
                            cnt <= cnt + 2'd1;
                        end
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_error_q <= 1'b0;
                        rsp_rdata_q <= 32'd0;
                        req_ready_q <= 1'b1;
                        cnt         <= 2'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_byte_mem.sv
// Directed scoreboard bench for lsu_byte_mem.
// u0 forbids misalignment, u1 allows it.
module tb_lsu_byte_mem;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        sel = 1'b0;
    logic        v   = 1'b0;
    logic        wr  = 1'b0;
    logic [2:0]  f3  = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wd  = 32'd0;
    logic        rr  = 1'b1;
    logic        dwe = 1'b0;
    logic [15:0] daddr = 16'd0;
    logic [7:0]  dwd = 8'd0;
    logic [7:0]  drd0;
    logic [7:0]  drd1;

    int checks = 0;
    int passes = 0;
    exp_t sb[$];

    lsu_byte_mem_if m0 ();
    lsu_byte_mem_if m1 ();

    assign m0.req_valid  = v & ~sel;
    assign m1.req_valid  = v & sel;
    assign m0.req_write  = wr;
    assign m1.req_write  = wr;
    assign m0.req_funct3 = f3;
    assign m1.req_funct3 = f3;
    assign m0.req_addr   = addr;
    assign m1.req_addr   = addr;
    assign m0.req_wdata  = wd;
    assign m1.req_wdata  = wd;
    assign m0.rsp_ready  = rr;
    assign m1.rsp_ready  = rr;

    wire        o_ready = sel ? m1.req_ready : m0.req_ready;
    wire        o_valid = sel ? m1.rsp_valid : m0.rsp_valid;
    wire        o_err   = sel ? m1.rsp_error : m0.rsp_error;
    wire [31:0] o_rdata = sel ? m1.rsp_rdata : m0.rsp_rdata;
    wire [7:0]  o_drd   = sel ? drd1 : drd0;

    lsu_byte_mem #(.ADDR_BITS(16), .ALLOW_MISALIGNED(1'b0)) u0 (
        .clk(clk), .rst(rst), .bus(m0.slave),
        .dbg_we(dwe & ~sel), .dbg_addr(daddr),
        .dbg_wdata(dwd), .dbg_rdata(drd0)
    );

    lsu_byte_mem #(.ADDR_BITS(16), .ALLOW_MISALIGNED(1'b1)) u1 (
        .clk(clk), .rst(rst), .bus(m1.slave),
        .dbg_we(dwe & sel), .dbg_addr(daddr),
        .dbg_wdata(dwd), .dbg_rdata(drd1)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        dwe = 1'b1; daddr = a; dwd = d;
        @(posedge clk);
        #1 dwe = 1'b0;
    endtask

    task automatic peek(input string tag, input logic [15:0] a,
                        input logic [7:0] e);
        daddr = a;
        #1 check(tag, 32'(o_drd), 32'(e));
    endtask

    task automatic xact(input string tag, input logic w,
                        input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] er,
                        input logic ee, input int el, input int hold);
        exp_t e;
        int lat;
        sb.push_back({er, ee});
        @(negedge clk);
        lat = 0;
        while (!o_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".ready"}, 32'(o_ready), 32'd1);
        rr = (hold == 0);
        v = 1'b1; wr = w; f3 = f; addr = a; wd = d;
        @(posedge clk);
        #1 v = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!o_valid && lat < 30);
        check({tag, ".latency"}, 32'(lat), 32'(el));
        check({tag, ".valid"}, 32'(o_valid), 32'd1);
        e = sb.pop_front();
        check({tag, ".rdata"}, o_rdata, e.rdata);
        check({tag, ".error"}, 32'(o_err), 32'(e.err));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, ".hold_valid"}, 32'(o_valid), 32'd1);
            check({tag, ".hold_rdata"}, o_rdata, e.rdata);
            check({tag, ".hold_ready"}, 32'(o_ready), 32'd0);
        end
        rr = 1'b1;
        @(posedge clk);
        #1;
        check({tag, ".done_valid"}, 32'(o_valid), 32'd0);
        check({tag, ".done_ready"}, 32'(o_ready), 32'd1);
    endtask

    initial begin
        #12;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("rst.ready", 32'(o_ready), 32'd1);
            check("rst.valid", 32'(o_valid), 32'd0);
            check("rst.rdata", o_rdata, 32'd0);
            check("rst.error", 32'(o_err), 32'd0);
        end
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        xact("sw10", 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0, 4, 0);
        xact("lw10", 0, 3'b010, 32'h10, 0, 32'hDEADBEEF, 0, 4, 0);
        peek("m10", 16'h10, 8'hEF);
        peek("m11", 16'h11, 8'hBE);
        peek("m12", 16'h12, 8'hAD);
        peek("m13", 16'h13, 8'hDE);

        xact("sb20", 1, 3'b000, 32'h20, 32'h80, 0, 0, 1, 0);
        xact("lb20", 0, 3'b000, 32'h20, 0, 32'hFFFFFF80, 0, 1, 0);
        xact("lbu20", 0, 3'b100, 32'h20, 0, 32'h00000080, 0, 1, 0);
        xact("sh22", 1, 3'b001, 32'h22, 32'h8001, 0, 0, 2, 0);
        xact("lh22", 0, 3'b001, 32'h22, 0, 32'hFFFF8001, 0, 2, 0);
        xact("lhu22", 0, 3'b101, 32'h22, 0, 32'h00008001, 0, 2, 0);

        xact("lw11err", 0, 3'b010, 32'h11, 0, 0, 1, 1, 0);
        peek("m11keep", 16'h11, 8'hBE);
        xact("sh21err", 1, 3'b001, 32'h21, 32'hFFFF, 0, 1, 1, 0);
        peek("m22keep", 16'h22, 8'h01);
        xact("f3_011", 0, 3'b011, 32'h10, 0, 0, 1, 1, 0);
        poke(16'h30, 8'hA5);
        xact("sbu_err", 1, 3'b100, 32'h30, 32'h55, 0, 1, 1, 0);
        peek("m30keep", 16'h30, 8'hA5);

        sel = 1'b1;
        poke(16'h14, 8'h00);
        xact("u1sw10", 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0, 4, 0);
        xact("u1lw11", 0, 3'b010, 32'h11, 0, 32'h00DEADBE, 0, 4, 0);
        xact("u1lh13", 0, 3'b001, 32'h13, 0, 32'h000000DE, 0, 2, 0);
        xact("wrapsw", 1, 3'b010, 32'hFFFE, 32'h11223344, 0, 0, 4, 5);
        peek("mFFFE", 16'hFFFE, 8'h44);
        peek("mFFFF", 16'hFFFF, 8'h33);
        peek("m0000", 16'h0000, 8'h22);
        peek("m0001", 16'h0001, 8'h11);
        xact("wraplw", 0, 3'b010, 32'hFFFE, 0, 32'h11223344, 0, 4, 5);

        sel = 1'b0;
        poke(16'h42, 8'h77);
        poke(16'h43, 8'h66);
        @(negedge clk);
        v = 1'b1; wr = 1'b1; f3 = 3'b010;
        addr = 32'h40; wd = 32'hCAFEF00D;
        @(posedge clk);
        #1 v = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst.ready", 32'(o_ready), 32'd1);
        check("midrst.valid", 32'(o_valid), 32'd0);
        peek("m40", 16'h40, 8'h0D);
        peek("m41", 16'h41, 8'hF0);
        peek("m42keep", 16'h42, 8'h77);
        peek("m43keep", 16'h43, 8'h66);
        @(negedge clk);
        rst = 1'b0;
        poke(16'h50, 8'h3C);
        peek("dbg50", 16'h50, 8'h3C);
        xact("lw40", 0, 3'b010, 32'h40, 0, 32'h6677F00D, 0, 4, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
